// File: rtl/accelerator_state_pkg.sv
// Shared types and constants for the state-feedback matrix sequencer family.
package accelerator_state_pkg;

  // Closed-loop matrix computations, in the order the engine runs them.
  typedef enum logic [1:0] {
    STAGE_A = 2'd0,
    STAGE_B = 2'd1,
    STAGE_C = 2'd2,
    STAGE_D = 2'd3
  } stage_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_STREAM,
    ST_WAIT,
    ST_NEXT,
    ST_DONE
  } seq_state_t;

  localparam logic [63:0] ZERO_DATA = 64'd0;
  localparam logic [63:0] ONE_DATA  = 64'd1;

  typedef struct packed {
    logic   found;
    stage_t stage;
  } stage_pick_t;

  // Lowest enabled stage, either from the bottom of the mask or strictly above cur.
  function automatic stage_pick_t pick_stage(input logic [3:0] mask,
                                             input stage_t     cur,
                                             input logic       from_start);
    stage_pick_t pick;
    pick.found = 1'b0;
    pick.stage = STAGE_A;
    for (int n = 3; n >= 0; n--) begin
      if (mask[n] && (from_start || (n > int'(cur)))) begin
        pick.found = 1'b1;
        pick.stage = stage_t'(n[1:0]);
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/accelerator_matrix_raster_counter.sv
// Row/column raster counter for matrix streaming: clear, advance on accept,
// column wrap into the next row, and last-element detect. Indices stop at
// the last element instead of wrapping, so they never exceed size-1.
module accelerator_matrix_raster_counter #(
  parameter int DATA_SIZE = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic                 advance,
  input  logic [DATA_SIZE-1:0] size_i,
  input  logic [DATA_SIZE-1:0] size_j,
  output logic [DATA_SIZE-1:0] index_i,
  output logic [DATA_SIZE-1:0] index_j,
  output logic [DATA_SIZE-1:0] index_j_next,
  output logic                 last_element
);
  import accelerator_state_pkg::*;

  localparam logic [DATA_SIZE-1:0] IDX_ZERO = DATA_SIZE'(ZERO_DATA);
  localparam logic [DATA_SIZE-1:0] IDX_ONE  = DATA_SIZE'(ONE_DATA);

  logic [DATA_SIZE-1:0] index_i_next;
  logic                 col_last;

  assign col_last     = (index_j == (size_j - IDX_ONE));
  assign last_element = (index_i == (size_i - IDX_ONE)) && col_last;

  // Next raster position.
  always_comb begin
    index_i_next = index_i;
    index_j_next = index_j;
    if (clear) begin
      index_i_next = IDX_ZERO;
      index_j_next = IDX_ZERO;
    end else if (advance && !last_element) begin
      if (col_last) begin
        index_j_next = IDX_ZERO;
        index_i_next = index_i + IDX_ONE;
      end else begin
        index_j_next = index_j + IDX_ONE;
      end
    end
  end

  // Index registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      index_i <= IDX_ZERO;
      index_j <= IDX_ZERO;
    end else begin
      index_i <= index_i_next;
      index_j <= index_j_next;
    end
  end

endmodule

// File: rtl/accelerator_state_feedback_sequencer.sv
// Drives the shared matrix engine through the enabled closed-loop stages
// (a, b, c, d in that order), streaming an I x J raster per stage.
//
// state  | meaning
// IDLE   | waiting for START; latches mask and sizes
// ISSUE  | ENGINE_START pulse, raster cleared
// STREAM | presenting elements, advancing on DATA_ACCEPT
// WAIT   | raster done, waiting for ENGINE_READY
// NEXT   | selecting the next enabled stage
// DONE   | READY pulse, then back to IDLE
module accelerator_state_feedback_sequencer #(
  parameter int DATA_SIZE    = 64,
  parameter int CONTROL_SIZE = 64
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 START,
  output logic                 READY,
  output logic                 ERROR,
  input  logic [3:0]           STAGE_MASK,
  input  logic [DATA_SIZE-1:0] SIZE_I_IN,
  input  logic [DATA_SIZE-1:0] SIZE_J_IN,
  output logic                 ENGINE_START,
  output logic [1:0]           ENGINE_STAGE,
  input  logic                 ENGINE_READY,
  output logic                 DATA_I_ENABLE,
  output logic                 DATA_J_ENABLE,
  output logic [DATA_SIZE-1:0] DATA_INDEX_I,
  output logic [DATA_SIZE-1:0] DATA_INDEX_J,
  input  logic                 DATA_ACCEPT
);
  import accelerator_state_pkg::*;

  // Control words are carried by the datapath, not here; only sanity-check the width.
  if (CONTROL_SIZE < 1) begin : g_control_size_check
    $error("CONTROL_SIZE must be positive");
  end

  localparam logic [DATA_SIZE-1:0] IDX_ZERO = DATA_SIZE'(ZERO_DATA);

  seq_state_t           state_q, state_d;
  stage_t               stage_q, stage_d;
  logic [3:0]           mask_q;
  logic [DATA_SIZE-1:0] size_i_q, size_j_q;

  logic                 capture, size_zero_in;
  stage_pick_t          pick_first, pick_after;

  logic                 raster_clear, raster_advance, raster_last;
  logic [DATA_SIZE-1:0] index_j_next;

  logic                 ready_d, error_d, engine_start_d, i_enable_d, j_enable_d;

  assign capture        = (state_q == ST_IDLE) && START;
  assign size_zero_in   = (SIZE_I_IN == IDX_ZERO) || (SIZE_J_IN == IDX_ZERO);
  assign pick_first     = pick_stage(STAGE_MASK, STAGE_A, 1'b1);
  assign pick_after     = pick_stage(mask_q, stage_q, 1'b0);
  assign raster_clear   = (state_q == ST_ISSUE);
  assign raster_advance = (state_q == ST_STREAM) && DATA_ACCEPT;
  assign ENGINE_STAGE   = stage_q;

  accelerator_matrix_raster_counter #(
    .DATA_SIZE (DATA_SIZE)
  ) u_raster (
    .clk          (CLK),
    .rst          (RST),
    .clear        (raster_clear),
    .advance      (raster_advance),
    .size_i       (size_i_q),
    .size_j       (size_j_q),
    .index_i      (DATA_INDEX_I),
    .index_j      (DATA_INDEX_J),
    .index_j_next (index_j_next),
    .last_element (raster_last)
  );

  // State and current-stage registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= ST_IDLE;
      stage_q <= STAGE_A;
    end else begin
      state_q <= state_d;
      stage_q <= stage_d;
    end
  end

  // Next state; a ready that coincides with the last accept is dropped because
  // the FSM is still in STREAM at that edge.
  always_comb begin
    state_d = state_q;
    stage_d = stage_q;
    case (state_q)
      ST_IDLE: begin
        if (START) begin
          if (size_zero_in) begin
            state_d = ST_DONE;
          end else if (pick_first.found) begin
            state_d = ST_ISSUE;
            stage_d = pick_first.stage;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_ISSUE:  state_d = ST_STREAM;
      ST_STREAM: if (DATA_ACCEPT && raster_last) state_d = ST_WAIT;
      ST_WAIT:   if (ENGINE_READY) state_d = ST_NEXT;
      ST_NEXT: begin
        if (pick_after.found) begin
          state_d = ST_ISSUE;
          stage_d = pick_after.stage;
        end else begin
          state_d = ST_DONE;
        end
      end
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Outputs for the coming cycle, decoded from the next state so they can be registered.
  always_comb begin
    engine_start_d = (state_d == ST_ISSUE);
    j_enable_d     = (state_d == ST_STREAM);
    i_enable_d     = j_enable_d && (index_j_next == IDX_ZERO);
    ready_d        = (state_d == ST_DONE);
    error_d        = capture ? size_zero_in : ERROR;
  end

  // Request capture; later changes on the inputs do not affect a running sequence.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      mask_q   <= 4'b0000;
      size_i_q <= IDX_ZERO;
      size_j_q <= IDX_ZERO;
    end else if (capture) begin
      mask_q   <= STAGE_MASK;
      size_i_q <= SIZE_I_IN;
      size_j_q <= SIZE_J_IN;
    end
  end

  // Output registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      READY         <= 1'b0;
      ERROR         <= 1'b0;
      ENGINE_START  <= 1'b0;
      DATA_I_ENABLE <= 1'b0;
      DATA_J_ENABLE <= 1'b0;
    end else begin
      READY         <= ready_d;
      ERROR         <= error_d;
      ENGINE_START  <= engine_start_d;
      DATA_I_ENABLE <= i_enable_d;
      DATA_J_ENABLE <= j_enable_d;
    end
  end

endmodule

// File: doc/accelerator_state_feedback_sequencer.md
Name: accelerator_state_feedback_sequencer

Overview:
- Sequences the shared state-feedback matrix engine through the four closed-loop matrix computations, in fixed order: a = A-B·K·inv(I+DK)·C, b = B·(I-K·inv(I+DK)·D), c = inv(I+DK)·C, d = inv(I+DK)·D.
- For each enabled stage it:
  - pulses the engine start,
  - walks an I×J element raster with I/J enables under accept backpressure,
  - waits for the engine's ready.
- Sits between the state-space top-level control and the matrix input/output datapath.

Parameters:
DATA_SIZE, 64, width of size and index buses
CONTROL_SIZE, 64, width of control words (reserved; unused internally)

Ports:
CLK  in  1  clock
RST  in  1  asynchronous active-high reset
START  in  1  begin a sequence (sampled in IDLE only)
READY  out  1  one-cycle pulse when the sequence completes
ERROR  out  1  set with READY when the sequence aborted on a zero size; cleared on next START
STAGE_MASK  in  4  bit n enables stage n (0=a, 1=b, 2=c, 3=d); sampled with START
SIZE_I_IN  in  DATA_SIZE  row count; sampled with START
SIZE_J_IN  in  DATA_SIZE  column count; sampled with START
ENGINE_START  out  1  one-cycle pulse per stage
ENGINE_STAGE  out  2  current stage code, stable from ENGINE_START to that stage's ENGINE_READY
ENGINE_READY  in  1  engine completion pulse
DATA_I_ENABLE  out  1  high on element where j==0
DATA_J_ENABLE  out  1  high on every streamed element
DATA_INDEX_I  out  DATA_SIZE  current row index
DATA_INDEX_J  out  DATA_SIZE  current column index
DATA_ACCEPT  in  1  consumer accepts current element this cycle

Behaviour:
- Interface: one clock; reset is asynchronous and active-high (CLK, RST).
- Reset values: all outputs 0; ENGINE_STAGE=0; indices 0; FSM=IDLE. RST asserted mid-sequence aborts immediately. No READY is produced for the aborted sequence.
- All outputs are registered.
- FSM states:
  - IDLE:
    - START=1 latches mask and sizes.
    - SIZE_I=0 or SIZE_J=0 -> DONE with ERROR=1.
    - Mask=0 -> DONE with ERROR=0.
    - Otherwise -> ISSUE on lowest set mask bit.
  - ISSUE: ENGINE_START=1 for exactly this cycle; ENGINE_STAGE=stage. Indices cleared -> STREAM.
  - STREAM:
    - J_ENABLE=1; I_ENABLE=(index_j==0); indices hold while DATA_ACCEPT=0.
    - On accept: j increments.
    - At j==SIZE_J-1, j wraps to 0 and i increments.
    - Accept of (SIZE_I-1, SIZE_J-1) -> WAIT; enables low the next cycle.
  - WAIT: ENGINE_READY=1 -> NEXT.
  - NEXT: next higher set mask bit -> ISSUE; none -> DONE.
  - DONE: READY=1 for one cycle -> IDLE.
- Latency:
  - START at edge t -> ENGINE_START during cycle t+1; element (0,0) presented in cycle t+2.
  - ENGINE_READY at edge r -> NEXT in cycle r+1. Then either ISSUE in r+2 or READY in r+2.
  - Zero-mask or zero-size: READY in cycle t+1.
- Element count per stage is exactly SIZE_I·SIZE_J, independent of stall pattern.
- Index width rules:
  - Comparisons use full DATA_SIZE width.
  - Counters never exceed SIZE-1.
  - Sizes are unsigned.
- Boundary conditions:
  - 1×1 matrix: a single element with I_ENABLE=J_ENABLE=1.
  - START while not IDLE: ignored.
  - ENGINE_READY outside WAIT: ignored, not latched.
  - ENGINE_READY and last-element accept in the same cycle: the ready is ignored. The engine must pulse ready after the last element.
  - Size/mask input changes during a sequence: no effect.

Decomposition:
- Shared package accelerator_state_pkg holds:
  - stage codes STAGE_A..STAGE_D (0..3);
  - FSM state enumeration;
  - ZERO_DATA/ONE_DATA constants.
- One natural sub-module: accelerator_matrix_raster_counter. It holds the I/J counters with accept, wrap and last-element detect, and is reused by other matrix controllers.

Test Plan:
- MASK=4'b1111, SIZE 2×3, ACCEPT always 1:
  - 4 ENGINE_START pulses with STAGE 0,1,2,3.
  - Each stage streams 6 elements, index order (0,0)(0,1)(0,2)(1,0)(1,1)(1,2).
  - I_ENABLE on (0,0) and (1,0) only.
  - READY once, ERROR=0.
- MASK=4'b1010, SIZE 1×1, ENGINE_READY 3 cycles after the element:
  - Stages 1 then 3 only.
  - One element each with both enables high.
  - READY exactly 2 cycles after the second ENGINE_READY.
- SIZE 3×2, ACCEPT toggling 1,0,1,0...:
  - Each index pair held while ACCEPT=0.
  - Exactly 6 accepted elements per stage.
- SIZE_J=0, MASK=4'b1111: no ENGINE_START; READY=1 and ERROR=1 in cycle t+1. A subsequent valid START clears ERROR.
- RST asserted mid-STREAM of stage 1 (asynchronous, between edges):
  - All outputs 0 immediately; no READY.
  - A new START after release restarts at stage 0.
- START re-asserted during WAIT and ENGINE_READY pulsed during STREAM: both ignored; sequence order and element count unchanged.
